wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 101 ++++++++++
 tb/tb_wb_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file with a three-state commit handshake, byte enables, bypass and a commit counter
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic                wb_en,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic [DATA_W/8-1:0] wb_be,
   output logic                fetch_start,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic [CNT_W-1:0]    commit_cnt
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;
   localparam bit ZR    = (ZERO_REG != 0);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMMIT  = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]        r_state;
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [NB-1:0]     r_be;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_wr;
   logic [DATA_W-1:0] w_merged;

   assign wb_ready    = (r_state == S_IDLE);
   assign fetch_start = (r_state == S_RELEASE);
   assign commit_cnt  = r_cnt;
   assign w_accept    = wb_ready && wb_valid;
   // A held write only lands if it is enabled, touches at least one byte and does not target a hard-wired zero register
   assign w_wr        = (r_state == S_COMMIT) && r_en && (|r_be) && !(ZR && (r_addr == '0));

   // Byte-merge of the held data over the currently stored value of the held register
   for (genvar i = 0; i < NB; i++) begin : g_merge
      assign w_merged[8*i +: 8] = r_be[i] ? r_data[8*i +: 8] : r_mem[r_addr][8*i +: 8];
   end

   // Read ports: zero register wins, then the pending write is forwarded, else the array
   assign rd_data_a = (ZR && (rd_addr_a == '0)) ? '0 :
                      (w_wr && (rd_addr_a == r_addr)) ? w_merged : r_mem[rd_addr_a];
   assign rd_data_b = (ZR && (rd_addr_b == '0)) ? '0 :
                      (w_wr && (rd_addr_b == r_addr)) ? w_merged : r_mem[rd_addr_b];

   // Handshake sequencing: IDLE accepts, COMMIT writes, RELEASE pulses fetch_start
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= (r_state == S_IDLE)   ? (wb_valid ? S_COMMIT : S_IDLE) :
                    (r_state == S_COMMIT) ? S_RELEASE : S_IDLE;
   end

   // Holding registers capture the request only on acceptance so later traffic cannot disturb it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_en   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_be   <= '0;
      end else if (w_accept) begin
         r_en   <= wb_en;
         r_addr <= wb_addr;
         r_data <= wb_data;
         r_be   <= wb_be;
      end
   end

   // Register array update on the edge leaving COMMIT
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else if (w_wr) begin
         r_mem[r_addr] <= w_merged;
      end
   end

   // Commit counter counts landed writes and sticks at all-ones
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (w_wr && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural register-file model
module tb_wb_regfile;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic [3:0]  wb_be = '0;
   logic [4:0]  rd_addr_a = '0;
   logic [4:0]  rd_addr_b = '0;
   logic        wb_ready, fetch_start, wb_ready2, fetch_start2;
   logic [31:0] rd_data_a, rd_data_b, rd_data_a2, rd_data_b2;
   logic [15:0] commit_cnt;
   logic [1:0]  commit_cnt2;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] mem [32];
   int          cnt;
   logic        pend_v;
   logic [4:0]  pend_a;
   logic [31:0] pend_d;

   always #5 clock = ~clock;

   wb_regfile dut (
      .clock(clock), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
      .fetch_start(fetch_start), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .commit_cnt(commit_cnt)
   );

   wb_regfile #(.CNT_W(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
      .fetch_start(fetch_start2), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a2), .rd_data_b(rd_data_b2), .commit_cnt(commit_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (pend_v && idx == pend_a) return pend_d;
      return mem[idx];
   endfunction

   function automatic logic [63:0] sat3(input int c);
      return (c > 3) ? 64'd3 : 64'(c);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) mem[k] = '0;
      cnt = 0;
      pend_v = 1'b0;
   endtask

   task automatic scan();
      for (int k = 0; k < 32; k++) begin
         rd_addr_a = 5'(k);
         rd_addr_b = 5'(31 - k);
         #1;
         check("scan_a", rd_data_a, exp_rd(5'(k)));
         check("scan_b", rd_data_b, exp_rd(5'(31 - k)));
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge after it is back in IDLE
   task automatic transact(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      logic sup;
      check("ready_idle", wb_ready, 1'b1);
      wb_valid = 1'b1; wb_en = en; wb_addr = a; wb_data = d; wb_be = be;
      @(posedge clock);
      @(negedge clock);
      wb_en = $urandom; wb_addr = $urandom; wb_data = $urandom; wb_be = $urandom;
      sup = !en || (be == 0) || (a == 0);
      pend_v = !sup; pend_a = a; pend_d = merge(mem[a], d, be);
      rd_addr_b = a;
      rd_addr_a = $urandom;
      #1;
      check("commit_ready", wb_ready, 1'b0);
      check("commit_fetch", fetch_start, 1'b0);
      check("bypass_b", rd_data_b, exp_rd(a));
      check("bypass_a", rd_data_a, exp_rd(rd_addr_a));
      check("same_idx", rd_data_a == rd_data_b, rd_addr_a == rd_addr_b || exp_rd(rd_addr_a) == exp_rd(a));
      @(posedge clock);
      if (!sup) begin mem[a] = pend_d; cnt++; end
      pend_v = 1'b0;
      @(negedge clock);
      rd_addr_a = a;
      rd_addr_b = $urandom;
      #1;
      check("release_fetch", fetch_start, 1'b1);
      check("release_ready", wb_ready, 1'b0);
      check("written_a", rd_data_a, exp_rd(a));
      check("other_b", rd_data_b, exp_rd(rd_addr_b));
      check("cnt", commit_cnt, 64'(cnt));
      check("cnt_sat", commit_cnt2, sat3(cnt));
      @(posedge clock);
      @(negedge clock);
      wb_valid = 1'b0;
      check("idle_fetch", fetch_start, 1'b0);
      check("idle_ready", wb_ready, 1'b1);
   endtask

   initial begin
      model_reset();
      @(negedge clock);
      check("rst_ready", wb_ready, 1'b1);
      check("rst_fetch", fetch_start, 1'b0);
      check("rst_cnt", commit_cnt, 64'd0);
      scan();
      reset_n = 1'b1;

      // Basic full-word write
      transact(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
      rd_addr_a = 5'd5; #1;
      check("basic_r5", rd_data_a, 64'hDEADBEEF);
      check("basic_cnt", commit_cnt, 64'd1);

      // Byte enables
      transact(1'b1, 5'd7, 32'h11223344, 4'hF);
      transact(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101);
      rd_addr_a = 5'd7; #1;
      check("be_r7", rd_data_a, 64'h11BB33DD);

      // Zero register and empty byte enables
      transact(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
      rd_addr_a = 5'd0; #1;
      check("zero_r0", rd_data_a, 64'h0);
      check("zero_cnt", commit_cnt, 64'd3);
      transact(1'b1, 5'd7, 32'hFFFFFFFF, 4'h0);
      check("nobe_cnt", commit_cnt, 64'd3);

      // Bypass of r9 during COMMIT
      transact(1'b1, 5'd9, 32'h12345678, 4'hF);
      check("r9_cnt2", commit_cnt2, 64'd3);

      // Continuous valid with token-only requests: accept every third cycle
      wb_valid = 1'b1; wb_en = 1'b0; wb_addr = 5'd9; wb_data = 32'hCAFEF00D; wb_be = 4'hF;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("bp_ready", wb_ready, (i % 3) == 0);
         check("bp_fetch", fetch_start, (i % 3) == 2);
         @(negedge clock);
      end
      wb_valid = 1'b0;
      check("bp_cnt", commit_cnt, 64'(cnt));
      scan();

      // Randomized traffic
      for (int t = 0; t < 40; t++)
         transact(($urandom % 5) != 0, 5'($urandom), $urandom, 4'($urandom));
      scan();

      // Reset asserted during COMMIT aborts the write and the fetch pulse
      transact(1'b1, 5'd3, 32'hAA, 4'hF);
      wb_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55; wb_be = 4'hF;
      @(posedge clock);
      @(negedge clock);
      wb_valid = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_ready", wb_ready, 1'b1);
      check("mid_rst_fetch", fetch_start, 1'b0);
      check("mid_rst_cnt", commit_cnt, 64'd0);
      @(posedge clock);
      @(negedge clock);
      check("mid_rst_fetch2", fetch_start, 1'b0);
      rd_addr_a = 5'd3; #1;
      check("mid_rst_r3", rd_data_a, 64'h0);
      scan();
      reset_n = 1'b1;

      // First edge after reset accepts; five writes saturate the 2-bit counter at 3
      for (int t = 0; t < 5; t++)
         transact(1'b1, 5'(t + 10), $urandom, 4'hF);
      check("sat_cnt16", commit_cnt, 64'd5);
      check("sat_cnt2", commit_cnt2, 64'd3);
      scan();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
